muskoka_timer: RTL



---
 rtl/muskoka_timer_pkg.sv | 18 +
 rtl/muskoka_timer_prescale.sv | 28 ++
 rtl/muskoka_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muskoka_timer_pkg.sv
// rtl/muskoka_timer_pkg.sv - register offsets and bit indices for muskoka_timer
package muskoka_timer_pkg;

  // Word offsets, decoded from wb_adr_i[4:2]
  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_LOAD   = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_STATUS = 3'd3;
  localparam logic [2:0] TMR_CAP    = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  localparam int STATUS_EXPIRED  = 0;
  localparam int STATUS_CAPTURED = 1;

endpackage

// File: rtl/muskoka_timer_prescale.sv
// rtl/muskoka_timer_prescale.sv - prescaler producing one tick every PRESCALE enabled cycles
module muskoka_timer_prescale #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = en && (cnt == LAST);

  // Held at 0 while disabled so a restart always yields a full first period
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/muskoka_timer.sv
// rtl/muskoka_timer.sv - Wishbone down-counting timer; MUSKOKA_TIMER_CAPTURE_EN adds input capture
module muskoka_timer
  import muskoka_timer_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
`ifdef MUSKOKA_TIMER_CAPTURE_EN
  input  logic        timer_cap_i,
`endif
  output logic        irq_o
);

  logic             ctrl_en, ctrl_ar, ctrl_ie;
  logic             expired;
  logic [CNT_W-1:0] load_q, count_q;
  logic [CNT_W-1:0] cap_q;
  logic             captured;

  logic             nxt_en;
  logic             nxt_expired;
  logic [CNT_W-1:0] nxt_count;

  logic [2:0]  reg_sel;
  logic        acc, wr, tick, tick_eff, expire_evt, clr_exp, ctrl_wr_off;
  logic [31:0] rdata;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign reg_sel = wb_adr_i[4:2];
  assign acc     = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign wr      = acc && wb_we_i;

  muskoka_timer_prescale #(.PRESCALE(PRESCALE)) u_prescale (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (ctrl_en),
    .tick (tick)
  );

  // A CTRL write clearing EN cancels the tick landing in the same cycle
  assign ctrl_wr_off = wr && (reg_sel == TMR_CTRL) && !wb_dat_i[CTRL_EN];
  assign tick_eff    = tick && !ctrl_wr_off;
  assign expire_evt  = tick_eff && (count_q == '0);
  assign clr_exp     = wr && (reg_sel == TMR_STATUS) && wb_dat_i[STATUS_EXPIRED];

  always_comb begin
    nxt_en      = ctrl_en;
    nxt_count   = count_q;
    nxt_expired = (expired && !clr_exp) || expire_evt;
    if (tick_eff) begin
      if (count_q != '0) begin
        nxt_count = count_q - 1'b1;
      end else if (ctrl_ar) begin
        nxt_count = load_q;
      end else begin
        nxt_en = 1'b0;
      end
    end
    // Bus writes override the counter's own update
    if (wr && (reg_sel == TMR_COUNT)) nxt_count = wb_dat_i[CNT_W-1:0];
    if (wr && (reg_sel == TMR_CTRL))  nxt_en    = wb_dat_i[CTRL_EN];
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      TMR_CTRL: begin
        rdata[CTRL_EN]          = ctrl_en;
        rdata[CTRL_AUTO_RELOAD] = ctrl_ar;
        rdata[CTRL_IRQ_EN]      = ctrl_ie;
      end
      TMR_LOAD:  rdata = 32'(load_q);
      TMR_COUNT: rdata = 32'(count_q);
      TMR_STATUS: begin
        rdata[STATUS_EXPIRED]  = expired;
        rdata[STATUS_CAPTURED] = captured;
      end
      TMR_CAP:   rdata = 32'(cap_q);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      expired  <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rdata : 32'h0;
      irq_o    <= expired && ctrl_ie;
      ctrl_en  <= nxt_en;
      count_q  <= nxt_count;
      expired  <= nxt_expired;
      if (wr && (reg_sel == TMR_CTRL)) begin
        ctrl_ar <= wb_dat_i[CTRL_AUTO_RELOAD];
        ctrl_ie <= wb_dat_i[CTRL_IRQ_EN];
      end
      if (wr && (reg_sel == TMR_LOAD)) load_q <= wb_dat_i[CNT_W-1:0];
    end
  end

`ifdef MUSKOKA_TIMER_CAPTURE_EN
  logic cap_sync, cap_prev, cap_rise, clr_cap;

  assign cap_rise = cap_sync && !cap_prev;
  assign clr_cap  = wr && (reg_sel == TMR_STATUS) && wb_dat_i[STATUS_CAPTURED];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_sync <= 1'b0;
      cap_prev <= 1'b0;
      cap_q    <= '0;
      captured <= 1'b0;
    end else begin
      cap_sync <= timer_cap_i;
      cap_prev <= cap_sync;
      if (cap_rise) cap_q <= count_q;
      captured <= (captured && !clr_cap) || cap_rise;
    end
  end
`else
  assign cap_q    = '0;
  assign captured = 1'b0;
`endif

endmodule
